// File: rtl/btn_event_decoder.sv
// -----------------------------------------------------------------------------
// btn_event_decoder
//
// Turns a debounced button level into gesture pulses for the watch mode and
// setting controllers: short press, long press, double click, and an
// auto-repeat pulse train while a long press stays held.
//
// All timing is measured in ticks of a free-running prescaler. The prescaler
// and the tick counter restart on every state change, so every timeout is an
// exact multiple of TICK_DIV clock cycles from the edge that caused it.
//
// Parameters
//   TICK_DIV  clk cycles per timing tick
//   LONG_T    ticks a first press must be held to become a long press
//   DBL_T     ticks after release in which a second press may start
//             (0 disables double-click detection)
//   REPEAT_T  ticks between repeat pulses while a long press is held
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   i_btn_level  debounced button level, 1 = pressed
//   o_short      one-cycle pulse, short press recognised
//   o_long       one-cycle pulse, long-press threshold reached
//   o_double     one-cycle pulse, double click recognised
//   o_repeat     one-cycle pulse, auto-repeat during a long press
//   o_held       level, button held in PRESSED / LONG_HELD / SECOND_PRESSED
//   o_state      current state code, for debug
//
// State table
//   state          | meaning
//   ---------------+---------------------------------------------------------
//   IDLE       (0) | waiting for a press
//   PRESSED    (1) | first press held, long-press timer running
//   LONG_HELD  (2) | long press recognised, repeat timer running
//   WAIT_SECOND(3) | first press released, double-click window open
//   SECOND_PRES(4) | second press held, double click on release
// -----------------------------------------------------------------------------
module btn_event_decoder #(
    parameter int TICK_DIV = 100000,
    parameter int LONG_T   = 1000,
    parameter int DBL_T    = 300,
    parameter int REPEAT_T = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_btn_level,
    output logic       o_short,
    output logic       o_long,
    output logic       o_double,
    output logic       o_repeat,
    output logic       o_held,
    output logic [2:0] o_state
);

    localparam int MAX_T_LD = (LONG_T > DBL_T) ? LONG_T : DBL_T;
    localparam int MAX_T    = (MAX_T_LD > REPEAT_T) ? MAX_T_LD : REPEAT_T;
    localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TW       = (MAX_T > 0) ? $clog2(MAX_T + 1) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] LONG_LAST  = TW'((LONG_T > 0) ? LONG_T - 1 : 0);
    localparam logic [TW-1:0] DBL_LAST   = TW'((DBL_T > 0) ? DBL_T - 1 : 0);
    localparam logic [TW-1:0] REP_LAST   = TW'((REPEAT_T > 0) ? REPEAT_T - 1 : 0);
    localparam logic [TW-1:0] TCNT_MAX   = {TW{1'b1}};
    localparam bit            DBL_EN     = (DBL_T > 0);

    typedef enum logic [2:0] {
        ST_IDLE           = 3'd0,
        ST_PRESSED        = 3'd1,
        ST_LONG_HELD      = 3'd2,
        ST_WAIT_SECOND    = 3'd3,
        ST_SECOND_PRESSED = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic            level_d;
    logic [PW-1:0]   presc;
    logic [TW-1:0]   tcnt;

    logic            rise;
    logic            fall;
    logic            tick;
    logic            tmo_long;
    logic            tmo_dbl;
    logic            tmo_rep;
    logic            state_chg;

    logic            short_nx;
    logic            long_nx;
    logic            double_nx;
    logic            repeat_nx;
    logic            tcnt_clr;

    // ------------------------------------------------------------------
    // Edge detection
    // ------------------------------------------------------------------
    // The level is sampled during reset as well, so a button that is
    // already held when reset is released does not look like a new press.
    always_ff @(posedge clk) begin
        level_d <= i_btn_level;
    end

    assign rise = i_btn_level & ~level_d;
    assign fall = ~i_btn_level & level_d;

    // ------------------------------------------------------------------
    // Timebase
    // ------------------------------------------------------------------
    assign tick     = (presc == PRESC_LAST);
    assign tmo_long = tick && (tcnt == LONG_LAST);
    assign tmo_dbl  = tick && (tcnt == DBL_LAST);
    assign tmo_rep  = tick && (tcnt == REP_LAST);

    assign state_chg = (state_nx != state);

    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            tcnt  <= '0;
        end else if (state_chg) begin
            presc <= '0;
            tcnt  <= '0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            // tcnt saturates so a long SECOND_PRESSED hold cannot wrap
            // around into a spurious timeout value.
            if (tcnt_clr) begin
                tcnt <= '0;
            end else if (tick && (tcnt != TCNT_MAX)) begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and pulse decisions
    // ------------------------------------------------------------------
    // Where a button edge and a timeout land in the same cycle the edge is
    // tested first, so the edge always wins.
    always_comb begin
        state_nx  = state;
        short_nx  = 1'b0;
        long_nx   = 1'b0;
        double_nx = 1'b0;
        repeat_nx = 1'b0;
        tcnt_clr  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (rise) begin
                    state_nx = ST_PRESSED;
                end
            end

            ST_PRESSED: begin
                if (fall) begin
                    if (DBL_EN) begin
                        state_nx = ST_WAIT_SECOND;
                    end else begin
                        short_nx = 1'b1;
                        state_nx = ST_IDLE;
                    end
                end else if (tmo_long) begin
                    long_nx  = 1'b1;
                    state_nx = ST_LONG_HELD;
                end
            end

            ST_LONG_HELD: begin
                if (fall) begin
                    state_nx = ST_IDLE;
                end else if (tmo_rep) begin
                    repeat_nx = 1'b1;
                    tcnt_clr  = 1'b1;
                end
            end

            ST_WAIT_SECOND: begin
                if (rise) begin
                    state_nx = ST_SECOND_PRESSED;
                end else if (tmo_dbl) begin
                    short_nx = 1'b1;
                    state_nx = ST_IDLE;
                end
            end

            ST_SECOND_PRESSED: begin
                if (fall) begin
                    double_nx = 1'b1;
                    state_nx  = ST_IDLE;
                end
            end

            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered pulse outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            o_short  <= 1'b0;
            o_long   <= 1'b0;
            o_double <= 1'b0;
            o_repeat <= 1'b0;
        end else begin
            o_short  <= short_nx;
            o_long   <= long_nx;
            o_double <= double_nx;
            o_repeat <= repeat_nx;
        end
    end

    assign o_held = (state == ST_PRESSED) ||
                    (state == ST_LONG_HELD) ||
                    (state == ST_SECOND_PRESSED);

    assign o_state = state;

endmodule
